// File: rtl/fft4_stream_if.sv
// Sample/bin stream bundle for fft4_stream: input handshake with mode bit,
// output handshake with bin index and last flag.
interface fft4_stream_if #(
    parameter int DW = 16
);
    logic                 inv;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [1:0]           out_idx;
    logic                 out_last;

    modport slave (
        input  inv, in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport master (
        output inv, in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );
endinterface

// File: rtl/fft4_stream.sv
// Streaming 4-point DFT: collects four samples, computes all bins in one
// cycle with exact DW+2 bit sums, then drains them in natural order.
module fft4_stream #(
    parameter int DW    = 16,
    parameter bit SCALE = 1'b1
) (
    input logic          clk,
    input logic          rst,
    fft4_stream_if.slave bus
);
    typedef enum logic [1:0] {FILL, COMPUTE, DRAIN} state_t;

    localparam int XW = DW + 2;
    localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    state_t               state;
    logic [1:0]           cnt;
    logic                 inv_q;
    logic signed [DW-1:0] s_re   [4];
    logic signed [DW-1:0] s_im   [4];
    logic signed [DW-1:0] bin_re [4];
    logic signed [DW-1:0] bin_im [4];

    logic signed [XW-1:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [XW-1:0] w1r, w1i, w3r, w3i;
    logic signed [XW-1:0] x_re [4];
    logic signed [XW-1:0] x_im [4];
    logic signed [DW-1:0] f_re [4];
    logic signed [DW-1:0] f_im [4];

    function automatic logic signed [XW-1:0] sx(input logic signed [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

    // Scaled output is floor(sum/4), which always fits DW bits.
    function automatic logic signed [DW-1:0] fmt(input logic signed [XW-1:0] s);
        if (SCALE)
            return DW'(s >>> 2);
        else if (s > SAT_MAX)
            return SAT_MAX[DW-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[DW-1:0];
        else
            return DW'(s);
    endfunction

    always_comb begin
        ar = sx(s_re[0]);  ai = sx(s_im[0]);
        br = sx(s_re[1]);  bi = sx(s_im[1]);
        cr = sx(s_re[2]);  ci = sx(s_im[2]);
        dr = sx(s_re[3]);  di = sx(s_im[3]);

        // Rotation by -j for bin 1 / +j for bin 3 in the forward direction.
        w1r = ar + bi - cr - di;
        w1i = ai - br - ci + dr;
        w3r = ar - bi - cr + di;
        w3i = ai + br - ci - dr;

        x_re[0] = ar + br + cr + dr;
        x_im[0] = ai + bi + ci + di;
        x_re[2] = ar - br + cr - dr;
        x_im[2] = ai - bi + ci - di;
        x_re[1] = inv_q ? w3r : w1r;
        x_im[1] = inv_q ? w3i : w1i;
        x_re[3] = inv_q ? w1r : w3r;
        x_im[3] = inv_q ? w1i : w3i;

        for (int unsigned k = 0; k < 4; k++) begin
            f_re[k] = fmt(x_re[k]);
            f_im[k] = fmt(x_im[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            cnt           <= '0;
            inv_q         <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.in_valid && bus.in_ready) begin
                        s_re[cnt] <= bus.in_re;
                        s_im[cnt] <= bus.in_im;
                        if (cnt == 2'd0)
                            inv_q <= bus.inv;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state        <= COMPUTE;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        bin_re[k] <= f_re[k];
                        bin_im[k] <= f_im[k];
                    end
                    bus.out_re    <= f_re[0];
                    bus.out_im    <= f_im[0];
                    bus.out_idx   <= '0;
                    bus.out_last  <= 1'b0;
                    bus.out_valid <= 1'b1;
                    state         <= DRAIN;
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (bus.out_idx == 2'd3) begin
                            state         <= FILL;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
                        end else begin
                            bus.out_idx  <= bus.out_idx + 2'd1;
                            bus.out_re   <= bin_re[bus.out_idx + 2'd1];
                            bus.out_im   <= bin_im[bus.out_idx + 2'd1];
                            bus.out_last <= (bus.out_idx == 2'd2);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fft4_stream.sv
// Directed bench for fft4_stream: one saturating and one scaling instance
// driven in lockstep from a table of hand-computed blocks plus corner sequences.
module tb_fft4_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        inv;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;

    always #5 clk = ~clk;

    fft4_stream_if #(.DW(16)) b0 ();
    fft4_stream_if #(.DW(16)) b1 ();

    assign b0.inv = inv;        assign b1.inv = inv;
    assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
    assign b0.in_re = in_re;    assign b1.in_re = in_re;
    assign b0.in_im = in_im;    assign b1.in_im = in_im;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;

    fft4_stream #(.DW(16), .SCALE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    fft4_stream #(.DW(16), .SCALE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct {
        string            name;
        logic             md;
        logic [3:0][15:0] re, im;      // samples a..d
        logic [3:0][15:0] s_re, s_im;  // expected bins, saturating instance
        logic [3:0][15:0] f_re, f_im;  // expected bins, scaling instance
    } vec_t;

    vec_t vt [8];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0][15:0] p4(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] r;
        r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
        return r;
    endfunction

    task automatic add(input int n, input string nm, input logic md,
                       input logic [3:0][15:0] re, input logic [3:0][15:0] im,
                       input logic [3:0][15:0] sr, input logic [3:0][15:0] si,
                       input logic [3:0][15:0] fr, input logic [3:0][15:0] fi);
        vt[n].name = nm; vt[n].md = md;
        vt[n].re = re;   vt[n].im = im;
        vt[n].s_re = sr; vt[n].s_im = si;
        vt[n].f_re = fr; vt[n].f_im = fi;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_bin(input int n, input int k);
        string p;
        p = $sformatf("%s k%0d", vt[n].name, k);
        chk({p, " sat re"},  int'($signed(b0.out_re)), int'($signed(vt[n].s_re[k])));
        chk({p, " sat im"},  int'($signed(b0.out_im)), int'($signed(vt[n].s_im[k])));
        chk({p, " scl re"},  int'($signed(b1.out_re)), int'($signed(vt[n].f_re[k])));
        chk({p, " scl im"},  int'($signed(b1.out_im)), int'($signed(vt[n].f_im[k])));
        chk({p, " idx"},     int'(b0.out_idx), k);
        chk({p, " scl idx"}, int'(b1.out_idx), k);
        chk({p, " last"},    int'(b0.out_last), (k == 3) ? 1 : 0);
    endtask

    task automatic send_sample(input logic [15:0] re, input logic [15:0] im, input logic md);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1; in_re = re; in_im = im; inv = md;
        while (!b0.in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) chk("in_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int n);
        for (int i = 0; i < 4; i++)
            send_sample(vt[n].re[i], vt[n].im[i], (i == 0) ? vt[n].md : ~vt[n].md);
    endtask

    task automatic recv_block(input int n, input int stall_k);
        int w;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            @(negedge clk);
            while (!b0.out_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (w >= 40) begin
                chk({vt[n].name, " out_valid timeout"}, 0, 1);
                out_ready = 1'b0;
                return;
            end
            chk_bin(n, k);
            if (k == stall_k) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk_bin(n, k);
                    chk("stall out_valid", int'(b0.out_valid), 1);
                    chk("stall in_ready", int'(b0.in_ready), 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk({vt[n].name, " end out_valid"}, int'(b0.out_valid), 0);
        chk({vt[n].name, " end scl out_valid"}, int'(b1.out_valid), 0);
        chk({vt[n].name, " end in_ready"}, int'(b0.in_ready), 1);
    endtask

    task automatic run_vec(input int n);
        send_block(n);
        recv_block(n, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        add(0, "impulse", 1'b0, p4(1000,0,0,0), p4(0,0,0,0),
            p4(1000,1000,1000,1000), p4(0,0,0,0), p4(250,250,250,250), p4(0,0,0,0));
        add(1, "tone_fwd", 1'b0, p4(100,0,-100,0), p4(0,100,0,-100),
            p4(0,400,0,0), p4(0,0,0,0), p4(0,100,0,0), p4(0,0,0,0));
        add(2, "tone_inv", 1'b1, p4(100,0,-100,0), p4(0,100,0,-100),
            p4(0,0,0,400), p4(0,0,0,0), p4(0,0,0,100), p4(0,0,0,0));
        add(3, "pos_full", 1'b0, p4(32767,32767,32767,32767), p4(0,0,0,0),
            p4(32767,0,0,0), p4(0,0,0,0), p4(32767,0,0,0), p4(0,0,0,0));
        add(4, "neg_full", 1'b0, p4(-32768,-32768,-32768,-32768), p4(0,0,0,0),
            p4(-32768,0,0,0), p4(0,0,0,0), p4(-32768,0,0,0), p4(0,0,0,0));
        add(5, "mixed_fwd", 1'b0, p4(1,3,-5,7), p4(2,-4,6,8),
            p4(6,-6,-14,18), p4(12,0,4,-8), p4(1,-2,-4,4), p4(3,0,1,-2));
        add(6, "mixed_inv", 1'b1, p4(1,3,-5,7), p4(2,-4,6,8),
            p4(6,18,-14,-6), p4(12,-8,4,0), p4(1,4,-4,-2), p4(3,-2,1,0));
        add(7, "alt_extreme", 1'b0, p4(32767,-32768,32767,-32768), p4(-32768,32767,-32768,32767),
            p4(-2,0,32767,0), p4(-2,0,-32768,0), p4(-1,0,32767,0), p4(-1,0,-32768,0));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inv = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", int'(b0.in_ready), 1);
        chk("reset out_valid", int'(b0.out_valid), 0);
        chk("reset out_re", int'($signed(b0.out_re)), 0);
        chk("reset out_im", int'($signed(b0.out_im)), 0);
        chk("reset out_idx", int'(b0.out_idx), 0);
        chk("reset out_last", int'(b0.out_last), 0);
        chk("reset scl out_valid", int'(b1.out_valid), 0);
        rst = 1'b0;

        for (int n = 0; n < 8; n++)
            run_vec(n);

        // Backpressure on bin 1 for five cycles
        send_block(5);
        recv_block(5, 1);

        // Idle gap between b and c, inv flipped after a, latency to X0
        send_sample(vt[6].re[0], vt[6].im[0], 1'b1);
        send_sample(vt[6].re[1], vt[6].im[1], 1'b0);
        repeat (3) @(posedge clk);
        send_sample(vt[6].re[2], vt[6].im[2], 1'b0);
        send_sample(vt[6].re[3], vt[6].im[3], 1'b0);
        chk("latency compute out_valid", int'(b0.out_valid), 0);
        chk("latency compute in_ready", int'(b0.in_ready), 0);
        @(posedge clk);
        #1;
        chk("latency X0 out_valid", int'(b0.out_valid), 1);
        chk("latency X0 re", int'($signed(b0.out_re)), 6);
        recv_block(6, -1);

        // Reset with a partial block buffered
        send_sample(16'd5000, 16'd5000, 1'b1);
        send_sample(16'd5000, 16'd5000, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midfill in_ready", int'(b0.in_ready), 1);
        chk("midfill out_valid", int'(b0.out_valid), 0);
        run_vec(0);

        // Reset while bins are draining
        send_block(5);
        out_ready = 1'b1;
        begin
            int w;
            w = 0;
            @(negedge clk);
            while (!b0.out_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (w >= 40) chk("middrain out_valid timeout", 0, 1);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("middrain pre idx", int'(b0.out_idx), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("middrain out_valid", int'(b0.out_valid), 0);
        chk("middrain in_ready", int'(b0.in_ready), 1);
        chk("middrain out_idx", int'(b0.out_idx), 0);
        chk("middrain out_re", int'($signed(b0.out_re)), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft4_stream.md
Name: fft4_stream

Overview:
- Streaming 4-point DFT engine: the next generation of the trivial-rotation (±1, ±j) multiplier.
- Accepts four complex samples serially over a valid/ready handshake, computes all four bins in one cycle, and emits them serially in natural order.
- Parametrised data width, output scaling or saturation, and per-block forward/inverse mode.
- Used as the radix-4 stage and the short-transform unit in the FFT datapath.

Parameters:
DW, 16, signed two's-complement width of the real/imag input and output components.
SCALE, 1, 1 = outputs divided by 4 (arithmetic shift right by 2, floor); 0 = full sum saturated to DW bits.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
inv  in  1  0 = forward DFT (W = -j), 1 = inverse (W = +j); sampled with the first sample of each block.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
in_re  in  DW  input real part, signed.
in_im  in  DW  input imaginary part, signed.
out_valid  out  1  output bin valid.
out_ready  in  1  downstream accepts the bin.
out_re  out  DW  output real part, signed.
out_im  out  DW  output imaginary part, signed.
out_idx  out  2  bin index k of the current output.
out_last  out  1  high with bin k=3.

Behaviour:
- Reset: state=FILL, sample count=0; in_ready=1; out_valid=0; out_re=out_im=0; out_idx=0; out_last=0; latched inv=0.
- A sample transfers when in_valid&in_ready; a bin transfers when out_valid&out_ready.
- FILL state:
  - in_ready=1; accepted samples are stored as a,b,c,d in order; counter runs 0..3.
  - inv is latched on acceptance of sample a.
  - When d is accepted, go to COMPUTE next cycle.
- COMPUTE state (one cycle):
  - in_ready=0, out_valid=0.
  - All four bins are computed at DW+2 bits from sign-extended operands, so the sums are exact, then registered.
  - Next state is DRAIN.
- Forward transform (inv=0):
  - X0 = a+b+c+d
  - X2 = a-b+c-d
  - X1r = ar+bi-cr-di; X1i = ai-br-ci+dr
  - X3r = ar-bi-cr+di; X3i = ai+br-ci-dr
- Inverse transform (inv=1): X1 and X3 formulas are swapped. No implicit 1/4 factor.
- Output formatting:
  - SCALE=1: out = sum >>> 2. Always fits in DW bits; no saturation.
  - SCALE=0: clamp sum to [-2^(DW-1), 2^(DW-1)-1].
- DRAIN state:
  - out_valid=1; bins are presented in order k=0,1,2,3 with out_idx=k and out_last=(k==3).
  - Outputs advance only on a transfer. While out_ready=0, outputs, out_idx and out_last are held stable.
  - in_ready=0 throughout DRAIN; there is no overlap of input and output blocks.
  - Transfer of k=3 → FILL next cycle with out_valid=0 and in_ready=1.
- Latency:
  - 4th sample accepted at edge t → COMPUTE during cycle t+1 → X0 valid from t+2.
  - Minimum block period is 9 cycles (4 in, 1 compute, 4 out).
- Input gaps: in_valid low in FILL simply stalls; partial blocks are held indefinitely.
- Reset mid-operation: rst in any state discards partial input and undrained bins; the next accepted sample is a of a new block.
- Data outputs when out_valid=0: hold their last value.
- The extreme input -2^(DW-1) is handled exactly; internal negation at DW+2 bits cannot overflow.

Test Plan:
1. Impulse, DW=16, SCALE=0, inv=0: a=(1000,0), b=c=d=(0,0) → all four bins (1000,0), out_idx 0..3, out_last only on k=3; with SCALE=1 → all bins (250,0).
2. Tone, SCALE=0: a=(100,0), b=(0,100), c=(-100,0), d=(0,-100).
   - inv=0 → X1=(400,0), others (0,0).
   - Same data with inv=1 → X3=(400,0), others (0,0).
3. Saturation, SCALE=0:
   - All four samples (32767,0) → X0=(32767,0), X1..X3=(0,0).
   - All four samples (-32768,0) → X0=(-32768,0).
   - SCALE=1 with all (-32768,0) → X0=(-32768,0).
4. Backpressure: hold out_ready=0 for 5 cycles after X1 is first presented → X1 value/idx stable, in_ready=0, no bin lost or duplicated; then 4 bins total per block.
5. Input stalls and mode latch: insert 3 idle cycles between b and c, and toggle inv after a is accepted → results match inv value at a; X0 appears exactly 2 cycles after d is accepted.
6. Reset mid-FILL: accept 2 samples, pulse rst one cycle, then send impulse block of case 1 → outputs equal case 1 exactly; reset asserted mid-DRAIN → out_valid=0 next cycle and in_ready=1.
